// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - arbitrates the instruction ROM read port between fetch (IF) and data-read (DR)
// Optional ROM_ARB_RR_EN: alternating conflict winner instead of fixed DR priority with a fetch starvation guard.

module rom_port_arbiter #(
   parameter int ROM_WORDS = 1024,
   parameter int MAX_WAIT  = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IF_REQ,
   input  logic [31:0] IF_ADDR,
   output logic        IF_GNT,
   output logic        IF_RVALID,
   output logic [31:0] IF_RDATA,
   output logic        IF_ERR,
   input  logic        DR_REQ,
   input  logic [31:0] DR_ADDR,
   output logic        DR_GNT,
   output logic        DR_RVALID,
   output logic [31:0] DR_RDATA,
   output logic        DR_ERR,
   output logic [31:0] ROM_ADDR,
   input  logic [31:0] ROM_DATA
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DR   = 2'd2
   } owner_t;

   localparam logic [32:0] ROM_BYTES = 33'(4 * ROM_WORDS);

   owner_t      owner_q, owner_d;
   logic        err_q, err_d;
   logic [31:0] rom_addr_q, rom_addr_d;
   logic        if_win;
   logic        any_gnt;
   logic [31:0] gnt_addr;
   logic        addr_err;

`ifdef ROM_ARB_RR_EN
   // 1 = IF won the last conflict; resetting to 1 hands the first conflict to DR.
   logic last_win_q, last_win_d;

   always_comb begin
      if_win     = IF_REQ && (!DR_REQ || !last_win_q);
      last_win_d = last_win_q;
      if (IF_REQ && DR_REQ && !RST) begin
         last_win_d = if_win;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         last_win_q <= 1'b1;
      end else begin
         last_win_q <= last_win_d;
      end
   end
`else
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [3:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      if_win     = IF_REQ && (!DR_REQ || (wait_cnt_q == MAX_WAIT_C));
      wait_cnt_d = 4'd0;
      if (IF_REQ && !IF_GNT) begin
         wait_cnt_d = (wait_cnt_q < MAX_WAIT_C) ? wait_cnt_q + 4'd1 : wait_cnt_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wait_cnt_q <= 4'd0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`endif

   always_comb begin
      IF_GNT   = !RST && if_win;
      DR_GNT   = !RST && DR_REQ && !if_win;
      any_gnt  = IF_GNT || DR_GNT;
      gnt_addr = IF_GNT ? IF_ADDR : DR_ADDR;
      addr_err = (gnt_addr[1:0] != 2'b00) || ({1'b0, gnt_addr} >= ROM_BYTES);
   end

   // The ROM address only moves on a grant so idle cycles do not toggle the ROM input.
   always_comb begin
      rom_addr_d = rom_addr_q;
      owner_d    = OWN_NONE;
      err_d      = 1'b0;
      if (any_gnt) begin
         rom_addr_d = {gnt_addr[31:2], 2'b00};
         owner_d    = IF_GNT ? OWN_IF : OWN_DR;
         err_d      = addr_err;
      end
      ROM_ADDR = rom_addr_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         owner_q    <= OWN_NONE;
         err_q      <= 1'b0;
         rom_addr_q <= 32'd0;
      end else begin
         owner_q    <= owner_d;
         err_q      <= err_d;
         rom_addr_q <= rom_addr_d;
      end
   end

   always_comb begin
      IF_RVALID = (owner_q == OWN_IF);
      DR_RVALID = (owner_q == OWN_DR);
      IF_ERR    = IF_RVALID && err_q;
      DR_ERR    = DR_RVALID && err_q;
      IF_RDATA  = (IF_RVALID && !err_q) ? ROM_DATA : 32'd0;
      DR_RDATA  = (DR_RVALID && !err_q) ? ROM_DATA : 32'd0;
   end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed self-checking bench for rom_port_arbiter
// Honours ROM_ARB_RR_EN for the conflict grant pattern.

module tb_rom_port_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IF_REQ, DR_REQ;
   logic [31:0] IF_ADDR, DR_ADDR;
   logic        IF_GNT, IF_RVALID, IF_ERR;
   logic        DR_GNT, DR_RVALID, DR_ERR;
   logic [31:0] IF_RDATA, DR_RDATA, ROM_ADDR;
   logic [31:0] ROM_DATA;
   logic [31:0] rom [0:1023];

   int n_chk  = 0;
   int n_pass = 0;

   rom_port_arbiter #(.ROM_WORDS(1024), .MAX_WAIT(4)) dut (
      .CLK(CLK), .RST(RST),
      .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT),
      .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA), .IF_ERR(IF_ERR),
      .DR_REQ(DR_REQ), .DR_ADDR(DR_ADDR), .DR_GNT(DR_GNT),
      .DR_RVALID(DR_RVALID), .DR_RDATA(DR_RDATA), .DR_ERR(DR_ERR),
      .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR[11:2]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic exp_if_win(input int c);
`ifdef ROM_ARB_RR_EN
      return (c % 2) == 1;
`else
      return (c % 5) == 4;
`endif
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 32'hA500_0000 + i;
      rom[2] = 32'h0000_0093;
      RST = 1'b1; IF_REQ = 1'b1; DR_REQ = 1'b1; IF_ADDR = 32'h0; DR_ADDR = 32'h0;
      step(); step();

      // reset state, requests held high while RST=1
      @(negedge CLK);
      check("rst_if_gnt", IF_GNT, 0);
      check("rst_dr_gnt", DR_GNT, 0);
      check("rst_if_rvalid", IF_RVALID, 0);
      check("rst_dr_rvalid", DR_RVALID, 0);
      check("rst_errs", {IF_ERR, DR_ERR}, 0);
      check("rst_rdata", IF_RDATA | DR_RDATA, 0);
      check("rst_rom_addr", ROM_ADDR, 0);
      step();
      RST = 1'b0; IF_REQ = 1'b0; DR_REQ = 1'b0;
      step();

      // single IF fetch at 0x8
      IF_REQ = 1'b1; IF_ADDR = 32'h8;
      @(negedge CLK);
      check("if_only_gnt", IF_GNT, 1);
      check("if_only_dr_gnt", DR_GNT, 0);
      check("if_only_rom_addr", ROM_ADDR, 32'h8);
      step();
      IF_REQ = 1'b0;
      @(negedge CLK);
      check("if_only_rvalid", IF_RVALID, 1);
      check("if_only_rdata", IF_RDATA, 32'h0000_0093);
      check("if_only_err", IF_ERR, 0);
      check("if_only_dr_rvalid", DR_RVALID, 0);
      step();

      // 12 cycles of conflict
      IF_REQ = 1'b1; IF_ADDR = 32'h20; DR_REQ = 1'b1; DR_ADDR = 32'h40;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         check($sformatf("conflict_if_gnt_%0d", c), IF_GNT, exp_if_win(c));
         check($sformatf("conflict_dr_gnt_%0d", c), DR_GNT, !exp_if_win(c));
         step();
      end
      IF_REQ = 1'b0; DR_REQ = 1'b0;
      step();

      // misaligned, out of range, and last valid word on DR
      DR_REQ = 1'b1; DR_ADDR = 32'h6;
      @(negedge CLK);
      check("mis_gnt", DR_GNT, 1);
      check("mis_rom_addr", ROM_ADDR, 32'h4);
      step();
      DR_ADDR = 32'h1000;
      @(negedge CLK);
      check("mis_rvalid", DR_RVALID, 1);
      check("mis_err", DR_ERR, 1);
      check("mis_rdata", DR_RDATA, 0);
      check("oor_gnt", DR_GNT, 1);
      step();
      DR_ADDR = 32'hFFC;
      @(negedge CLK);
      check("oor_rvalid", DR_RVALID, 1);
      check("oor_err", DR_ERR, 1);
      check("oor_rdata", DR_RDATA, 0);
      step();
      DR_REQ = 1'b0;
      @(negedge CLK);
      check("last_word_rvalid", DR_RVALID, 1);
      check("last_word_err", DR_ERR, 0);
      check("last_word_rdata", DR_RDATA, 32'hA500_03FF);
      step();

      // back-to-back IF fetches 0x0..0xC
      for (int k = 0; k < 5; k++) begin
         IF_REQ = (k < 4); IF_ADDR = 32'(4 * k);
         @(negedge CLK);
         if (k < 4) check($sformatf("b2b_gnt_%0d", k), IF_GNT, 1);
         if (k > 0) begin
            check($sformatf("b2b_rvalid_%0d", k - 1), IF_RVALID, 1);
            check($sformatf("b2b_rdata_%0d", k - 1), IF_RDATA, (k - 1 == 2) ? 32'h93 : 32'hA500_0000 + 32'(k - 1));
         end
         step();
      end
      @(negedge CLK);
      check("b2b_done_rvalid", IF_RVALID, 0);
      step();

      // grant at 0x10 then 5 idle cycles
      IF_REQ = 1'b1; IF_ADDR = 32'h10;
      step();
      IF_REQ = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check($sformatf("idle_rom_addr_%0d", i), ROM_ADDR, 32'h10);
         check($sformatf("idle_if_rvalid_%0d", i), IF_RVALID, (i == 0));
         check($sformatf("idle_dr_rvalid_%0d", i), DR_RVALID, 0);
         if (i == 0) check("idle_rdata", IF_RDATA, 32'hA500_0004);
         step();
      end

      // wait counter cleared by the idle period: fresh conflict restarts the pattern
      IF_REQ = 1'b1; DR_REQ = 1'b1; DR_ADDR = 32'h40;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         check($sformatf("reconflict_if_gnt_%0d", c), IF_GNT, exp_if_win(c));
         step();
      end
      IF_REQ = 1'b0; DR_REQ = 1'b0;
      step(); step();

      // reset right after a grant drops the response
      IF_REQ = 1'b1; IF_ADDR = 32'hC;
      @(negedge CLK);
      check("rstdrop_gnt", IF_GNT, 1);
      step();
      RST = 1'b1;
      @(negedge CLK);
      check("rstdrop_no_gnt", IF_GNT, 0);
      step();
      @(negedge CLK);
      check("rstdrop_rvalid", IF_RVALID, 0);
      check("rstdrop_rdata", IF_RDATA, 0);
      check("rstdrop_rom_addr", ROM_ADDR, 0);
      check("rstdrop_no_gnt2", IF_GNT | DR_GNT, 0);
      RST = 1'b0; IF_REQ = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Arbitrates the single read port of the instruction ROM between two requesters: the core's instruction fetch (IF) and a data-read port (DR, used for loads of constant tables held in ROM). Presents one word-aligned byte address per cycle on the ROM's INS_ADDRESS input and returns the ROM's INSTRUCTION_OUT word to the granted requester one cycle later. It includes a starvation guard for fetch and an alignment/range checker. It sits between the fetch stage, the load/store unit and the ROM.

## Interface
- ROM_WORDS, 1024: ROM depth in 32-bit words; valid byte addresses are 0 .. 4*ROM_WORDS-4.
- MAX_WAIT, 4: maximum consecutive cycles IF may be denied while requesting before it is forced to win (range 1..15).
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- IF_REQ  in  1  fetch request, level; held until granted.
- IF_ADDR  in  32  fetch byte address, stable while IF_REQ=1.
- IF_GNT  out  1  combinational grant, same cycle as accepted request.
- IF_RVALID  out  1  response valid, registered, one cycle after IF_GNT.
- IF_RDATA  out  32  response word; equals ROM_DATA while IF_RVALID=1 and no error, else 0.
- IF_ERR  out  1  response error flag, valid with IF_RVALID.
- DR_REQ, DR_ADDR, DR_GNT, DR_RVALID, DR_RDATA, DR_ERR: same as the IF_* set, for the data-read requester.
- ROM_ADDR  out  32  byte address to ROM INS_ADDRESS.
- ROM_DATA  in  32  ROM INSTRUCTION_OUT; valid the cycle after ROM_ADDR is presented.

## Operation
- Exactly one grant per cycle at most; IF_GNT and DR_GNT are never both 1.
- Only one requester: it is granted immediately.
- Both requesting: DR wins by default (fixed priority). IF wins instead when its wait counter WAIT_CNT == MAX_WAIT.
- WAIT_CNT is a 4-bit register:
  - increments when IF_REQ=1 and IF_GNT=0;
  - clears when IF_GNT=1 or IF_REQ=0;
  - saturates at MAX_WAIT.
- On grant, ROM_ADDR = {granted_addr[31:2], 2'b00}. With no grant, ROM_ADDR holds its previous value (no spurious toggling).
- Error check on the granted address: ERR if addr[1:0] != 0 or addr >= 4*ROM_WORDS. The ROM response is still requested, but RDATA is forced to 0 and ERR=1 in the response cycle.
- Response tracking uses registered state OWNER ∈ {NONE, IF, DR} plus an ERR_Q bit, loaded each cycle from the current grant.
  - Next cycle: the RVALID of OWNER is 1; the other RVALID is 0.
- Back-to-back grants are allowed every cycle: the pipeline is one deep and needs no backpressure on responses. Requesters must accept RVALID the cycle it is asserted.

## Timing
- Reset values: IF_RVALID=0, DR_RVALID=0, IF_ERR=0, DR_ERR=0, IF_RDATA=0, DR_RDATA=0, ROM_ADDR=0, OWNER=NONE, WAIT_CNT=0.
- GNT is combinational on REQ, WAIT_CNT and RST; GNT=0 whenever RST=1.
- Latency from GNT (cycle N) to RVALID (cycle N+1) is exactly 1 cycle.
- RST asserted in cycle N+1 after a grant in cycle N drops the pending response: RVALID=0 from the following edge, no partial response.
- Request deasserted in the cycle after its grant: the response is still delivered. A grant is a commitment.
- Simultaneous first requests after reset: DR granted (WAIT_CNT=0). IF is granted no later than MAX_WAIT cycles later under continuous DR traffic.

## Configuration
- ROM_ARB_RR_EN defined: on conflict, the winner is the requester that did not win the previous conflict. A 1-bit LAST_WIN register, reset to DR, updates only on conflict cycles. WAIT_CNT and the forced-grant logic are omitted; worst-case IF wait is 1 cycle.
- ROM_ARB_RR_EN undefined: fixed DR priority with the MAX_WAIT starvation guard, as described above.

## Test plan
- IF only, IF_ADDR=0x0000_0008, ROM word 2 = 0x0000_0093 -> IF_GNT=1 in the same cycle, ROM_ADDR=0x8; next cycle IF_RVALID=1, IF_RDATA=0x0000_0093, IF_ERR=0.
- IF and DR both held high for 12 cycles, MAX_WAIT=4, macro undefined -> grant pattern DR,DR,DR,DR,IF repeating; IF_GNT never 0 for more than 4 consecutive requesting cycles. With ROM_ARB_RR_EN defined -> strict alternation, DR first.
- DR_ADDR=0x0000_0006 (misaligned), then DR_ADDR=0x0000_1000 with ROM_WORDS=1024 (out of range) -> each gets DR_RVALID=1, DR_ERR=1, DR_RDATA=0 one cycle after grant.
- Back-to-back IF fetches at 0x0,0x4,0x8,0xC on consecutive cycles -> four consecutive IF_RVALID pulses carrying ROM words 0..3 in order, no gaps.
- Grant IF in cycle N, RST=1 in cycle N+1 -> IF_RVALID=0 at N+2, all outputs at reset values, and no grant while RST=1.
- No requests for 5 cycles after a grant at 0x10 -> ROM_ADDR stays 0x10, both RVALID=0, WAIT_CNT=0.
